// File: rtl/mips_ctrl_pkg.sv
// Shared opcodes, state encodings, datapath select codes and the control-strobe
// bundle for the multi-cycle MIPS control unit.
package mips_ctrl_pkg;

  localparam int OPCODE_W = 6;
  localparam int ST_W     = 4;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

  // FETCH is encoded as zero so the reset-gated debug view equals an all-zero bus.
  typedef enum logic [ST_W-1:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMRD    = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWR    = 4'd5,
    ST_RTYPE_EX = 4'd6,
    ST_RTYPE_WB = 4'd7,
    ST_BEQ_EX   = 4'd8,
    ST_ADDI_EX  = 4'd9,
    ST_ORI_EX   = 4'd10,
    ST_IMM_WB   = 4'd11,
    ST_JUMP     = 4'd12
  } state_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       ext_sel;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic state_e decode_next(input logic [OPCODE_W-1:0] op);
    state_e nxt;
    case (op)
      OP_LW, OP_SW: nxt = ST_MEMADR;
      OP_RTYPE:     nxt = ST_RTYPE_EX;
      OP_BEQ:       nxt = ST_BEQ_EX;
      OP_ADDI:      nxt = ST_ADDI_EX;
      OP_ORI:       nxt = ST_ORI_EX;
      OP_J:         nxt = ST_JUMP;
      default:      nxt = ST_FETCH;
    endcase
    return nxt;
  endfunction

  function automatic logic op_legal(input logic [OPCODE_W-1:0] op);
    return decode_next(op) != ST_FETCH;
  endfunction

endpackage

// File: rtl/mips_ctrl_out_decode.sv
// Combinational state -> control-strobe ROM. FETCH and MEMWR strobes that depend
// on mem_ready, and the DECODE illegal flag, are qualified here as well.
module mips_ctrl_out_decode
  import mips_ctrl_pkg::*;
(
  input  state_e                state_i,
  input  logic [OPCODE_W-1:0]   opcode_i,
  input  logic                  mem_ready_i,
  output ctrl_t                 ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      ST_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.iord      = 1'b0;
        ctrl_o.alu_src_a = 1'b0;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      ST_DECODE: begin
        ctrl_o.alu_src_a  = 1'b0;
        ctrl_o.alu_src_b  = SRCB_IMM_SH2;
        ctrl_o.alu_op     = ALU_ADD;
        ctrl_o.illegal_op = !op_legal(opcode_i);
        ctrl_o.instr_done = !op_legal(opcode_i);
      end
      ST_MEMADR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      ST_MEMRD: begin
        ctrl_o.iord     = 1'b1;
        ctrl_o.mem_read = 1'b1;
      end
      ST_MEMWB: begin
        ctrl_o.reg_dst    = 1'b0;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      ST_MEMWR: begin
        ctrl_o.iord       = 1'b1;
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      ST_RTYPE_EX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      ST_RTYPE_WB: begin
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      ST_BEQ_EX: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_B;
        ctrl_o.alu_op        = ALU_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
        ctrl_o.instr_done    = 1'b1;
      end
      ST_ADDI_EX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.ext_sel   = 1'b0;
      end
      ST_ORI_EX: begin
        // ori takes a zero-extended immediate, unlike the arithmetic forms
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_OR;
        ctrl_o.ext_sel   = 1'b1;
      end
      ST_IMM_WB: begin
        ctrl_o.reg_dst    = 1'b0;
        ctrl_o.mem_to_reg = 1'b0;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      ST_JUMP: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PCSRC_JUMP;
        ctrl_o.instr_done = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Moore control FSM for the multi-cycle MIPS datapath: state register, next-state
// logic and a reset gate that silences every strobe while reset is asserted.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ST_W     = 4
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic                mem_ready_i,
  output logic                pc_write_o,
  output logic                pc_write_cond_o,
  output logic                iord_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic                ir_write_o,
  output logic                mem_to_reg_o,
  output logic                reg_dst_o,
  output logic                reg_write_o,
  output logic                alu_src_a_o,
  output logic [1:0]          alu_src_b_o,
  output logic [1:0]          alu_op_o,
  output logic [1:0]          pc_source_o,
  output logic                ext_sel_o,
  output logic                instr_done_o,
  output logic                illegal_op_o,
  output logic [ST_W-1:0]     state_dbg_o
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl_raw;
  ctrl_t  ctrl_gated;

  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:    state_d = mem_ready_i ? ST_DECODE : ST_FETCH;
      ST_DECODE:   state_d = decode_next(opcode_i);
      ST_MEMADR:   state_d = (opcode_i == OP_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:    state_d = mem_ready_i ? ST_MEMWB : ST_MEMRD;
      ST_MEMWB:    state_d = ST_FETCH;
      ST_MEMWR:    state_d = mem_ready_i ? ST_FETCH : ST_MEMWR;
      ST_RTYPE_EX: state_d = ST_RTYPE_WB;
      ST_RTYPE_WB: state_d = ST_FETCH;
      ST_BEQ_EX:   state_d = ST_FETCH;
      ST_ADDI_EX:  state_d = ST_IMM_WB;
      ST_ORI_EX:   state_d = ST_IMM_WB;
      ST_IMM_WB:   state_d = ST_FETCH;
      ST_JUMP:     state_d = ST_FETCH;
      default:     state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= ST_FETCH;
    else         state_q <= state_d;
  end

  mips_ctrl_out_decode u_out_decode (
    .state_i     (state_q),
    .opcode_i    (opcode_i),
    .mem_ready_i (mem_ready_i),
    .ctrl_o      (ctrl_raw)
  );

  // Gate is combinational so a mid-instruction reset kills strobes in the same cycle.
  assign ctrl_gated = reset_i ? '0 : ctrl_raw;

  assign pc_write_o      = ctrl_gated.pc_write;
  assign pc_write_cond_o = ctrl_gated.pc_write_cond;
  assign iord_o          = ctrl_gated.iord;
  assign mem_read_o      = ctrl_gated.mem_read;
  assign mem_write_o     = ctrl_gated.mem_write;
  assign ir_write_o      = ctrl_gated.ir_write;
  assign mem_to_reg_o    = ctrl_gated.mem_to_reg;
  assign reg_dst_o       = ctrl_gated.reg_dst;
  assign reg_write_o     = ctrl_gated.reg_write;
  assign alu_src_a_o     = ctrl_gated.alu_src_a;
  assign alu_src_b_o     = ctrl_gated.alu_src_b;
  assign alu_op_o        = ctrl_gated.alu_op;
  assign pc_source_o     = ctrl_gated.pc_source;
  assign ext_sel_o       = ctrl_gated.ext_sel;
  assign instr_done_o    = ctrl_gated.instr_done;
  assign illegal_op_o    = ctrl_gated.illegal_op;
  assign state_dbg_o     = reset_i ? ST_FETCH : state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: directed vector table, hand-written wait/reset
// sequences, then randomized traffic checked against a per-instruction step model.
module tb_mips_multicycle_control;
  import mips_ctrl_pkg::*;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       ext_sel;
    logic       instr_done;
    logic       illegal_op;
    logic [3:0] state_dbg;
  } exp_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       rdy;
    exp_t       exp;
  } vec_t;

  typedef enum int {P_FETCH, P_DEC, P_MADR, P_MRD, P_MWB, P_MWR, P_REX, P_RWB,
                    P_BEQ, P_ADDI, P_ORI, P_IWB, P_J} phase_e;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic [5:0] opcode_i = 6'h00;
  logic       mem_ready_i = 1'b0;
  logic       pc_write_o, pc_write_cond_o, iord_o, mem_read_o, mem_write_o, ir_write_o;
  logic       mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o, ext_sel_o;
  logic       instr_done_o, illegal_op_o;
  logic [1:0] alu_src_b_o, alu_op_o, pc_source_o;
  logic [3:0] state_dbg_o;

  int n_vec = 0;
  int n_err = 0;

  phase_e     q[$];
  logic [5:0] cur_op = 6'h00;
  logic       use_fixed = 1'b0;
  logic [5:0] fixed_op = 6'h00;
  vec_t       tbl[$];

  always #5 clk_i = ~clk_i;

  mips_multicycle_control dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .opcode_i        (opcode_i),
    .mem_ready_i     (mem_ready_i),
    .pc_write_o      (pc_write_o),
    .pc_write_cond_o (pc_write_cond_o),
    .iord_o          (iord_o),
    .mem_read_o      (mem_read_o),
    .mem_write_o     (mem_write_o),
    .ir_write_o      (ir_write_o),
    .mem_to_reg_o    (mem_to_reg_o),
    .reg_dst_o       (reg_dst_o),
    .reg_write_o     (reg_write_o),
    .alu_src_a_o     (alu_src_a_o),
    .alu_src_b_o     (alu_src_b_o),
    .alu_op_o        (alu_op_o),
    .pc_source_o     (pc_source_o),
    .ext_sel_o       (ext_sel_o),
    .instr_done_o    (instr_done_o),
    .illegal_op_o    (illegal_op_o),
    .state_dbg_o     (state_dbg_o)
  );

  function automatic exp_t actual();
    exp_t a;
    a.pc_write      = pc_write_o;
    a.pc_write_cond = pc_write_cond_o;
    a.iord          = iord_o;
    a.mem_read      = mem_read_o;
    a.mem_write     = mem_write_o;
    a.ir_write      = ir_write_o;
    a.mem_to_reg    = mem_to_reg_o;
    a.reg_dst       = reg_dst_o;
    a.reg_write     = reg_write_o;
    a.alu_src_a     = alu_src_a_o;
    a.alu_src_b     = alu_src_b_o;
    a.alu_op        = alu_op_o;
    a.pc_source     = pc_source_o;
    a.ext_sel       = ext_sel_o;
    a.instr_done    = instr_done_o;
    a.illegal_op    = illegal_op_o;
    a.state_dbg     = state_dbg_o;
    return a;
  endfunction

  task automatic chk(input string nm, input exp_t e);
    exp_t a;
    a = actual();
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  // ---------------- reference model: instruction = list of steps ----------------
  function automatic logic legal(input logic [5:0] op);
    return op inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h0D, 6'h23, 6'h2B};
  endfunction

  function automatic logic waits(input phase_e p);
    return p inside {P_FETCH, P_MRD, P_MWR};
  endfunction

  task automatic model_start(input logic [5:0] op);
    cur_op = op;
    q.delete();
    q.push_back(P_FETCH);
    q.push_back(P_DEC);
    case (op)
      6'h23: begin q.push_back(P_MADR); q.push_back(P_MRD); q.push_back(P_MWB); end
      6'h2B: begin q.push_back(P_MADR); q.push_back(P_MWR); end
      6'h00: begin q.push_back(P_REX); q.push_back(P_RWB); end
      6'h04: q.push_back(P_BEQ);
      6'h08: begin q.push_back(P_ADDI); q.push_back(P_IWB); end
      6'h0D: begin q.push_back(P_ORI); q.push_back(P_IWB); end
      6'h02: q.push_back(P_J);
      default: ;
    endcase
  endtask

  function automatic exp_t model_exp(input phase_e p, input logic rdy, input logic [5:0] op);
    exp_t e;
    e = '0;
    case (p)
      P_FETCH: begin e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.ir_write = rdy;
                     e.pc_write = rdy; e.state_dbg = ST_FETCH; end
      P_DEC:   begin e.alu_src_b = 2'b11; e.illegal_op = !legal(op);
                     e.instr_done = !legal(op); e.state_dbg = ST_DECODE; end
      P_MADR:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.state_dbg = ST_MEMADR; end
      P_MRD:   begin e.iord = 1'b1; e.mem_read = 1'b1; e.state_dbg = ST_MEMRD; end
      P_MWB:   begin e.mem_to_reg = 1'b1; e.reg_write = 1'b1; e.instr_done = 1'b1;
                     e.state_dbg = ST_MEMWB; end
      P_MWR:   begin e.iord = 1'b1; e.mem_write = 1'b1; e.instr_done = rdy;
                     e.state_dbg = ST_MEMWR; end
      P_REX:   begin e.alu_src_a = 1'b1; e.alu_op = 2'b10; e.state_dbg = ST_RTYPE_EX; end
      P_RWB:   begin e.reg_dst = 1'b1; e.reg_write = 1'b1; e.instr_done = 1'b1;
                     e.state_dbg = ST_RTYPE_WB; end
      P_BEQ:   begin e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_write_cond = 1'b1;
                     e.pc_source = 2'b01; e.instr_done = 1'b1; e.state_dbg = ST_BEQ_EX; end
      P_ADDI:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.state_dbg = ST_ADDI_EX; end
      P_ORI:   begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 2'b11;
                     e.ext_sel = 1'b1; e.state_dbg = ST_ORI_EX; end
      P_IWB:   begin e.reg_write = 1'b1; e.instr_done = 1'b1; e.state_dbg = ST_IMM_WB; end
      P_J:     begin e.pc_write = 1'b1; e.pc_source = 2'b10; e.instr_done = 1'b1;
                     e.state_dbg = ST_JUMP; end
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic logic [5:0] pick_op();
    logic [5:0] ops [7] = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h0D, 6'h23, 6'h2B};
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return ops[r];
    return 6'($urandom_range(0, 63));
  endfunction

  // One clock: drive at the falling edge, compare 2 units later, advance the model.
  task automatic run_cycle(input logic rst, input logic rdy, input string nm);
    exp_t e;
    if (q.size() == 0) model_start(use_fixed ? fixed_op : pick_op());
    @(negedge clk_i);
    reset_i     = rst;
    mem_ready_i = rdy;
    opcode_i    = cur_op;
    #2;
    e = rst ? exp_t'('0) : model_exp(q[0], rdy, cur_op);
    chk(nm, e);
    if (rst) q.delete();
    else if (!(waits(q[0]) && !rdy)) void'(q.pop_front());
  endtask

  task automatic add(input logic rst, input logic [5:0] op, input logic rdy, input exp_t e);
    vec_t v;
    v.rst = rst; v.op = op; v.rdy = rdy; v.exp = e;
    tbl.push_back(v);
  endtask

  initial begin
    exp_t e_zero, e_fetch, e_fwait, e_dec, e_imm_wb;
    int cnt_mw, cnt_done, done_cyc;

    e_zero   = '0;
    e_fetch  = '{mem_read:1'b1, alu_src_b:2'b01, ir_write:1'b1, pc_write:1'b1,
                 state_dbg:ST_FETCH, default:'0};
    e_fwait  = '{mem_read:1'b1, alu_src_b:2'b01, state_dbg:ST_FETCH, default:'0};
    e_dec    = '{alu_src_b:2'b11, state_dbg:ST_DECODE, default:'0};
    e_imm_wb = '{reg_write:1'b1, instr_done:1'b1, state_dbg:ST_IMM_WB, default:'0};

    add(1'b1, 6'h00, 1'b1, e_zero);
    add(1'b1, 6'h00, 1'b1, e_zero);
    // lw, zero wait states: 5 cycles, writeback strobes only in cycle 5
    add(1'b0, 6'h23, 1'b1, e_fetch);
    add(1'b0, 6'h23, 1'b1, e_dec);
    add(1'b0, 6'h23, 1'b1, '{alu_src_a:1'b1, alu_src_b:2'b10, state_dbg:ST_MEMADR, default:'0});
    add(1'b0, 6'h23, 1'b1, '{iord:1'b1, mem_read:1'b1, state_dbg:ST_MEMRD, default:'0});
    add(1'b0, 6'h23, 1'b1, '{mem_to_reg:1'b1, reg_write:1'b1, instr_done:1'b1,
                             state_dbg:ST_MEMWB, default:'0});
    add(1'b0, 6'h04, 1'b1, e_fetch);
    add(1'b0, 6'h04, 1'b1, e_dec);
    add(1'b0, 6'h04, 1'b1, '{alu_src_a:1'b1, alu_op:2'b01, pc_write_cond:1'b1, pc_source:2'b01,
                             instr_done:1'b1, state_dbg:ST_BEQ_EX, default:'0});
    add(1'b0, 6'h02, 1'b1, e_fetch);
    add(1'b0, 6'h02, 1'b1, e_dec);
    add(1'b0, 6'h02, 1'b1, '{pc_write:1'b1, pc_source:2'b10, instr_done:1'b1,
                             state_dbg:ST_JUMP, default:'0});
    add(1'b0, 6'h3F, 1'b1, e_fetch);
    add(1'b0, 6'h3F, 1'b1, '{alu_src_b:2'b11, illegal_op:1'b1, instr_done:1'b1,
                             state_dbg:ST_DECODE, default:'0});
    add(1'b0, 6'h0D, 1'b1, e_fetch);
    add(1'b0, 6'h0D, 1'b1, e_dec);
    add(1'b0, 6'h0D, 1'b1, '{alu_src_a:1'b1, alu_src_b:2'b10, alu_op:2'b11, ext_sel:1'b1,
                             state_dbg:ST_ORI_EX, default:'0});
    add(1'b0, 6'h0D, 1'b1, e_imm_wb);
    add(1'b0, 6'h08, 1'b1, e_fetch);
    add(1'b0, 6'h08, 1'b1, e_dec);
    add(1'b0, 6'h08, 1'b1, '{alu_src_a:1'b1, alu_src_b:2'b10, state_dbg:ST_ADDI_EX, default:'0});
    add(1'b0, 6'h08, 1'b1, e_imm_wb);
    add(1'b0, 6'h00, 1'b0, e_fwait);
    add(1'b0, 6'h00, 1'b1, e_fetch);
    add(1'b0, 6'h00, 1'b1, e_dec);
    add(1'b0, 6'h00, 1'b1, '{alu_src_a:1'b1, alu_op:2'b10, state_dbg:ST_RTYPE_EX, default:'0});
    add(1'b0, 6'h00, 1'b1, '{reg_dst:1'b1, reg_write:1'b1, instr_done:1'b1,
                             state_dbg:ST_RTYPE_WB, default:'0});

    foreach (tbl[i]) begin
      @(negedge clk_i);
      reset_i     = tbl[i].rst;
      opcode_i    = tbl[i].op;
      mem_ready_i = tbl[i].rdy;
      #2;
      chk($sformatf("tbl[%0d]", i), tbl[i].exp);
    end

    // sw with three wait cycles in MEMWR
    run_cycle(1'b1, 1'b1, "sync_reset");
    use_fixed = 1'b1;
    fixed_op  = 6'h2B;
    cnt_mw = 0; cnt_done = 0; done_cyc = -1;
    for (int i = 0; i < 7; i++) begin
      run_cycle(1'b0, (i >= 3 && i < 6) ? 1'b0 : 1'b1, $sformatf("sw_wait[%0d]", i));
      if (mem_write_o) cnt_mw++;
      if (instr_done_o) begin cnt_done++; done_cyc = i; end
    end
    chk_int("sw_mem_write_cycles", cnt_mw, 4);
    chk_int("sw_instr_done_count", cnt_done, 1);
    chk_int("sw_total_cycles", done_cyc + 1, 7);

    // reset held 2 cycles while stalled in MEMWR
    for (int i = 0; i < 5; i++)
      run_cycle(1'b0, (i < 3) ? 1'b1 : 1'b0, $sformatf("sw_to_memwr[%0d]", i));
    chk_int("memwr_before_reset", int'(state_dbg_o), int'(ST_MEMWR));
    run_cycle(1'b1, 1'b0, "reset_mid_memwr0");
    run_cycle(1'b1, 1'b1, "reset_mid_memwr1");
    run_cycle(1'b0, 1'b0, "after_reset");
    chk_int("after_reset_state", int'(state_dbg_o), int'(ST_FETCH));

    // randomized traffic, occasional reset
    use_fixed = 1'b0;
    q.delete();
    for (int i = 0; i < 600; i++) begin
      run_cycle(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, $sformatf("rand[%0d]", i));
      n_vec++;
      if ((mem_read_o && mem_write_o) || (reg_write_o && pc_write_o)) begin
        n_err++;
        $display("FAIL exclusive_strobes[%0d]: mr=%0b mw=%0b rw=%0b pcw=%0b required no overlap",
                 i, mem_read_o, mem_write_o, reg_write_o, pc_write_o);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
